counter_bank: RTL
=================

# counter_bank

Parametrised bank of independent up/down counters: the general-purpose successor to the fixed four-register increment/decrement block. Each channel has its own enable, direction, and synchronous load, and reports overflow or underflow events. It sits beside control logic that needs event counting, timeouts, or credit tracking. Every channel is registered and all channels share one clock.

## Interface
Parameters:
- WIDTH, default 32: bits per counter, legal range 2..64.
- CHANNELS, default 4: number of independent counters, legal range 1..16.

Ports:
- clock, input, 1: the single clock. All state updates on posedge.
- rst_n, input, 1: asynchronous, active-low reset.
- en, input, CHANNELS: per-channel step enable.
- dir, input, CHANNELS: per-channel direction. 0 = up (+1), 1 = down (−1).
- load, input, CHANNELS: per-channel synchronous load strobe.
- load_value, input, CHANNELS×WIDTH: per-channel load data.
- count, output, CHANNELS×WIDTH: registered counter values.
- wrap, output, CHANNELS: registered one-cycle pulse, asserted the cycle after a channel stepped past its bound.
- any_wrap, output, 1: registered OR of the next-state wrap bits. Coincident with wrap.

## Operation
- Each channel is independent. There is no cross-channel interaction except any_wrap.
- Per-channel priority at each posedge is load > en > hold:
  - load=1: count ← load_value. wrap ← 0. en and dir are ignored.
  - load=0, en=1, dir=0: count ← count+1, modulo 2^WIDTH.
  - load=0, en=1, dir=1: count ← count−1, modulo 2^WIDTH.
  - load=0, en=0: count holds. wrap ← 0.
- A wrap event is an up-step from all-ones or a down-step from zero. On a wrap event, wrap ← 1 for exactly one cycle. No other step sets wrap.
- Arithmetic is performed at WIDTH bits. The carry/borrow out of WIDTH is the wrap condition. The count is never widened or sign-extended.
- Increment and decrement only update state. The block has no combinational path that returns a pre-step or post-step value.

## Timing
- All outputs are registered with 1-cycle latency. Inputs sampled at posedge N are visible on count, wrap, and any_wrap after posedge N.
- No combinational input-to-output paths.
- Reset: while rst_n=0, count=0, wrap=0, and any_wrap=0 in every channel, asynchronously and immediately. The first update occurs on the first posedge with rst_n=1.
- Reset asserted mid-operation clears all state immediately. A pending wrap pulse is lost.
- en held high steps the channel every cycle. Back-to-back wraps, for example WIDTH=2 counting continuously, produce wrap=1 in every cycle where the step crossed the bound.
- Toggling dir between consecutive cycles is legal. Each step uses the dir sampled on that edge.

## Configuration
- Macro: COUNTER_BANK_SATURATE_EN.
- Undefined (default): modulo wrap as described in Operation.
- Defined:
  - An up-step at all-ones holds all-ones.
  - A down-step at zero holds zero.
  - wrap pulses for every such blocked step, so it stays high continuously while en stays high at the bound.
  - load behaviour is unchanged.
- The macro selects behaviour for all channels. Mixed per-channel mode is not supported.

## Structure
- Package counter_bank_pkg holds:
  - the direction constants DIR_UP=1'b0 and DIR_DOWN=1'b1;
  - a localparam for maximum CHANNELS (16) and WIDTH (64), for parameter checks;
  - a function step_fn(value, dir, saturate) returning {wrap, next_value}.
- Sub-module counter_channel implements one counter: WIDTH parameter, plus en, dir, load, load_value, count, and wrap ports.
- counter_bank instantiates CHANNELS copies of counter_channel in a generate loop and builds any_wrap.
- Elaboration-time check: fail if a parameter is out of its legal range.

## Test plan
All scenarios use WIDTH=8 and CHANNELS=4.
1. Reset: hold rst_n=0 with en=4'hF. Then release and hold en=0 → all count=0, wrap=0, any_wrap=0. Assert rst_n=0 asynchronously mid-count → count=0 before the next edge.
2. Independent steps over 5 cycles:
   - ch0 up, ch1 down from load 10, ch2 disabled, ch3 up with en every other cycle.
   - After 5 cycles → count = {ch0=5, ch1=5, ch2=0, ch3=3}. wrap stays 0.
3. Wrap up and down:
   - Load ch0=8'hFE, up-step twice → counts FF then 00. wrap[0]=1 only in the cycle count shows 00.
   - Load ch1=8'h01, down-step twice → 00 then FF. wrap[1] pulses once.
   - any_wrap mirrors both pulses.
4. Priority: load=1, en=1, dir=0, load_value=8'h42 on ch2 → count=42, wrap=0. On the next edge with load=0 and en=1 → count=43.
5. Direction toggle: ch3 from 100, alternating dir each cycle for 6 cycles with en=1 → count returns to 100 and never wraps.
6. With COUNTER_BANK_SATURATE_EN defined:
   - ch0 loaded FF, up-stepped 3 cycles → count stays FF, wrap=1 for 3 cycles.
   - ch1 loaded 00, down-stepped → count stays 00, wrap=1.

Source files
------------

// File: rtl/counter_bank_pkg.sv
// Shared types, limits and step arithmetic for the counter_bank block.
package counter_bank_pkg;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  localparam int unsigned MAX_CHANNELS = 16;
  localparam int unsigned MAX_WIDTH    = 64;

  typedef struct packed {
    logic                 wrap;
    logic [MAX_WIDTH-1:0] value;
  } step_t;

  // One step of a width-bit counter carried in a MAX_WIDTH container.
  // wrap is the carry/borrow out of the active width.
  function automatic step_t step_fn(input logic [MAX_WIDTH-1:0] value,
                                    input int unsigned          width,
                                    input logic                 dir,
                                    input logic                 saturate);
    logic [MAX_WIDTH-1:0] mask;
    logic                 at_bound;
    step_t                res;
    mask     = (width >= MAX_WIDTH) ? '1
                                    : ((MAX_WIDTH'(1) << width) - MAX_WIDTH'(1));
    at_bound = (dir == DIR_UP) ? ((value & mask) == mask)
                               : ((value & mask) == '0);
    res.wrap = at_bound;
    if (at_bound && saturate) begin
      res.value = value & mask;
    end else if (dir == DIR_UP) begin
      res.value = (value + MAX_WIDTH'(1)) & mask;
    end else begin
      res.value = (value - MAX_WIDTH'(1)) & mask;
    end
    return res;
  endfunction

endpackage

// File: rtl/counter_bank_channel.sv
// One up/down counter with load > enable > hold priority.
// COUNTER_BANK_SATURATE_EN selects saturating instead of modulo stepping.
module counter_channel
  import counter_bank_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             wrap_c
);

`ifdef COUNTER_BANK_SATURATE_EN
  localparam logic SATURATE = 1'b1;
`else
  localparam logic SATURATE = 1'b0;
`endif

  step_t            step;
  logic [WIDTH-1:0] count_d;

  assign step = step_fn(MAX_WIDTH'(count), WIDTH, dir, SATURATE);

  // Next-state selection; wrap_c feeds the bank-level any_wrap register.
  always_comb begin
    count_d = count;
    wrap_c  = 1'b0;
    if (load) begin
      count_d = load_value;
    end else if (en) begin
      count_d = WIDTH'(step.value);
      wrap_c  = step.wrap;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      count <= count_d;
      wrap  <= wrap_c;
    end
  end

endmodule

// File: rtl/counter_bank.sv
// Bank of CHANNELS independent up/down counters with a shared any_wrap flag.
// Build option: COUNTER_BANK_SATURATE_EN (saturate at bounds instead of wrapping).
module counter_bank
  import counter_bank_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned CHANNELS = 4
) (
  input  logic                      clock,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS-1:0]       dir,
  input  logic [CHANNELS-1:0]       load,
  input  logic [CHANNELS*WIDTH-1:0] load_value,
  output logic [CHANNELS*WIDTH-1:0] count,
  output logic [CHANNELS-1:0]       wrap,
  output logic                      any_wrap
);

  if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("counter_bank: WIDTH %0d outside 2..%0d", WIDTH, MAX_WIDTH);
  end
  if (CHANNELS < 1 || CHANNELS > MAX_CHANNELS) begin : g_bad_channels
    $error("counter_bank: CHANNELS %0d outside 1..%0d", CHANNELS, MAX_CHANNELS);
  end

  logic [CHANNELS-1:0] wrap_c;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    counter_channel #(.WIDTH(WIDTH)) u_channel (
      .clock      (clock),
      .rst_n      (rst_n),
      .en         (en[i]),
      .dir        (dir[i]),
      .load       (load[i]),
      .load_value (load_value[i*WIDTH +: WIDTH]),
      .count      (count[i*WIDTH +: WIDTH]),
      .wrap       (wrap[i]),
      .wrap_c     (wrap_c[i])
    );
  end

  // Built from next-state wrap bits so it lines up with the per-channel pulses.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      any_wrap <= 1'b0;
    end else begin
      any_wrap <= |wrap_c;
    end
  end

endmodule
